conv_out_packer: RTL and testbench
==================================

// Module: conv_out_packer
// PURPOSE
// - Output stage directly downstream of conv_kern: takes the serial 8-bit activation
//   stream (acc_o/vld_o) and packs 16 activations into one 128-bit word.
// - Writes each word to the output line BRAM (w_addr/w_data/w_en) from a base address.
// - Raises done once the configured activation count is written. The convolution FSM
//   uses done as the conv_done condition.
// PARAMETERS
// - ACT_BITS            8    width of one activation
// - PACK_NUM            16   activations per BRAM word
// - W_DATA_W            128  ACT_BITS*PACK_NUM, BRAM word width
// - MAX_IFM_LINE_DEPTH  8    BRAM address width (4096/16 = 256 words)
// - CNT_BITS            18   width of the activation-count config
// PORTS
// - clk            in   1                   clock, rising edge
// - rstn           in   1                   async active-low reset
// - start          in   1                   1-cycle pulse; latches config, begins a layer
// - num_act        in   CNT_BITS            activations expected this layer
// - base_addr      in   MAX_IFM_LINE_DEPTH  first BRAM word address
// - is_last_layer  in   1                   last layer of the network (see CONFIGURATION)
// - vld_i          in   1                   act_i valid (from conv_kern vld_o)
// - act_i          in   ACT_BITS            activation (from conv_kern acc_o)
// - w_en           out  1                   BRAM write strobe
// - w_addr         out  MAX_IFM_LINE_DEPTH  BRAM word address
// - w_data         out  W_DATA_W            packed word
// - busy           out  1                   high from start until the done cycle
// - done           out  1                   1-cycle completion pulse
// - drop_err       out  1                   sticky; an activation was dropped
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, all counters and the lane buffer cleared.
// - States and transitions:
//   - IDLE:    start -> COLLECT if num_act != 0, else -> DONE.
//   - COLLECT: accepts act_i on every cycle vld_i=1. No backpressure.
//              Sustains 1 activation/clk.
//   - FLUSH:   entered when the last activation fills only a partial word.
//   - DONE:    done=1 for one cycle -> IDLE.
// - Packing: the k-th accepted activation of a word goes to lane k, bits [8k+7:8k].
//   Lane 0 is the first activation.
// - Full-word write: when lane 15 is accepted at edge T, w_en=1 in cycle T+1 with the
//   full word and w_addr = base_addr + word_idx; word_idx then increments.
//   Collection continues in T+1 without a bubble, using a separate output register.
// - Last activation accepted at edge T:
//   - If it completes a word: normal write in T+1.
//   - Otherwise: FLUSH writes the partial word in T+1, unused upper lanes zero.
//   - In both cases done=1 in T+2 and busy drops with done.
// - num_act=0: no write; done=1 two cycles after start.
// - w_en is high for exactly one cycle per word.
// - w_data and w_addr hold their last values when w_en=0.
// - Address arithmetic is modulo 2^MAX_IFM_LINE_DEPTH (0xFF+1 -> 0x00).
// - drop_err:
//   - Set when vld_i=1 in IDLE, FLUSH or DONE, or after num_act activations are taken.
//   - The dropped activation is discarded. Cleared only by start or reset.
// - start while busy: ignored; config is not relatched.
// - start and vld_i in the same cycle: that activation is dropped and flagged.
// - Reset mid-layer: immediate return to IDLE. No further w_en; partial data lost.
// CONFIGURATION
// - `CONV_OUT_RELU_EN defined:
//   - Each activation is treated as signed.
//   - If bit 7 = 1 and is_last_layer = 0, the activation is stored as 0x00.
//   - is_last_layer is latched at start.
// - Undefined: activations are stored unmodified and is_last_layer is ignored.
// TESTING
// - T1: base=0x10, num_act=16, act 0x01..0x10 on consecutive cycles
//       -> one write, addr 0x10, data 0x100F..0201; done 2 clk after the last vld.
// - T2: base=0x00, num_act=20, act 0x01..0x14
//       -> addr 0x00 full word; addr 0x01 data 0x...0014131211, lanes 4-15 = 0.
// - T3: num_act=32, vld_i toggling 1/0 every cycle
//       -> same packed data as back-to-back; 2 writes; no drop_err.
// - T4: base=0xFF, num_act=32 -> writes at addr 0xFF, then 0x00 (wrap).
// - T5: num_act=0 -> no w_en; done 2 clk after start.
//       Then vld_i pulse while IDLE -> drop_err=1 until the next start.
// - T6 (RELU_EN): act 0x80,0x7F,0xFF,0x00 x4, is_last_layer=0
//       -> lanes read 0x00,0x7F,0x00,0x00.
//       Repeat with is_last_layer=1 -> values stored unchanged.
//       Assert rstn mid-word -> no w_en afterwards.

Source files
------------

// File: rtl/conv_out_packer.sv
// Packs the serial activation stream from conv_kern into 128-bit line-BRAM words.
// Optional ReLU on non-final layers is enabled by defining CONV_OUT_RELU_EN.
module conv_out_packer #(
   parameter int ACT_BITS           = 8,
   parameter int PACK_NUM           = 16,
   parameter int W_DATA_W           = ACT_BITS * PACK_NUM,
   parameter int MAX_IFM_LINE_DEPTH = 8,
   parameter int CNT_BITS           = 18
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          start,
   input  logic [CNT_BITS-1:0]           num_act,
   input  logic [MAX_IFM_LINE_DEPTH-1:0] base_addr,
   input  logic                          is_last_layer,
   input  logic                          vld_i,
   input  logic [ACT_BITS-1:0]           act_i,
   output logic                          w_en,
   output logic [MAX_IFM_LINE_DEPTH-1:0] w_addr,
   output logic [W_DATA_W-1:0]           w_data,
   output logic                          busy,
   output logic                          done,
   output logic                          drop_err
);

   localparam int LANE_W = $clog2(PACK_NUM);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_FLUSH   = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0]                    state;
   logic [CNT_BITS-1:0]           num_q;
   logic [CNT_BITS-1:0]           taken;
   logic [CNT_BITS-1:0]           taken_nxt;
   logic [MAX_IFM_LINE_DEPTH-1:0] base_q;
   logic [MAX_IFM_LINE_DEPTH-1:0] word_idx;
   logic [LANE_W-1:0]             lane;
   logic [W_DATA_W-1:0]           lane_buf;
   logic [W_DATA_W-1:0]           buf_ins;
   logic [ACT_BITS-1:0]           act_st;
   logic                          accept;
   logic                          last_act;
   logic                          lane_full;

`ifdef CONV_OUT_RELU_EN
   logic last_layer_q;

   function automatic logic [ACT_BITS-1:0] relu_fn(input logic signed [ACT_BITS-1:0] a,
                                                   input logic                       pass);
      if (!pass && (a < 0))
         return '0;
      return a;
   endfunction

   assign act_st = relu_fn(act_i, last_layer_q);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         last_layer_q <= 1'b0;
      else if ((state == S_IDLE) && start)
         last_layer_q <= is_last_layer;
   end
`else
   logic unused_last_layer;

   assign unused_last_layer = is_last_layer;
   assign act_st            = act_i;
`endif

   assign accept    = (state == S_COLLECT) && vld_i && (taken != num_q);
   assign taken_nxt = taken + CNT_BITS'(1);
   assign last_act  = (taken_nxt == num_q);
   assign lane_full = (lane == LANE_W'(PACK_NUM - 1));

   always_comb begin
      buf_ins = lane_buf;
      buf_ins[lane*ACT_BITS +: ACT_BITS] = act_st;
   end

   // Accept stage: lane insert; completed words move to the separate output register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= S_IDLE;
         num_q    <= '0;
         base_q   <= '0;
         taken    <= '0;
         word_idx <= '0;
         lane     <= '0;
         lane_buf <= '0;
         w_en     <= 1'b0;
         w_addr   <= '0;
         w_data   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         drop_err <= 1'b0;
      end else begin
         w_en <= 1'b0;
         done <= 1'b0;
         if (vld_i && !accept)
            drop_err <= 1'b1;

         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_COLLECT;
                  num_q    <= num_act;
                  base_q   <= base_addr;
                  taken    <= '0;
                  word_idx <= '0;
                  lane     <= '0;
                  lane_buf <= '0;
                  busy     <= 1'b1;
                  drop_err <= vld_i;
               end
            end
            S_COLLECT: begin
               if (accept) begin
                  taken <= taken_nxt;
                  if (lane_full || last_act) begin
                     w_en     <= 1'b1;
                     w_data   <= buf_ins;
                     w_addr   <= base_q + word_idx;
                     word_idx <= word_idx + MAX_IFM_LINE_DEPTH'(1);
                     lane     <= '0;
                     lane_buf <= '0;
                     if (!lane_full)
                        state <= S_FLUSH;
                  end else begin
                     lane     <= lane + LANE_W'(1);
                     lane_buf <= buf_ins;
                  end
               end else if (taken == num_q) begin
                  // Full last word (or empty layer): its write already went out last cycle
                  state <= S_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            S_FLUSH: begin
               state <= S_DONE;
               done  <= 1'b1;
               busy  <= 1'b0;
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_out_packer.sv
// Directed self-checking bench for conv_out_packer (both with and without CONV_OUT_RELU_EN).
module tb_conv_out_packer;

   logic         clk = 1'b0;
   logic         rstn;
   logic         start;
   logic [17:0]  num_act;
   logic [7:0]   base_addr;
   logic         is_last_layer;
   logic         vld_i;
   logic [7:0]   act_i;
   logic         w_en;
   logic [7:0]   w_addr;
   logic [127:0] w_data;
   logic         busy;
   logic         done;
   logic         drop_err;

   conv_out_packer dut (
      .clk          (clk),
      .rstn         (rstn),
      .start        (start),
      .num_act      (num_act),
      .base_addr    (base_addr),
      .is_last_layer(is_last_layer),
      .vld_i        (vld_i),
      .act_i        (act_i),
      .w_en         (w_en),
      .w_addr       (w_addr),
      .w_data       (w_data),
      .busy         (busy),
      .done         (done),
      .drop_err     (drop_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int done_cyc = -1;
   int done_cnt = 0;
   int n_chk = 0;
   int n_pass = 0;
   logic [7:0]   wa_q[$];
   logic [127:0] wd_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (w_en) begin
         wa_q.push_back(w_addr);
         wd_q.push_back(w_data);
      end
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_layer(input logic [17:0] n, input logic [7:0] b, input logic last);
      num_act       = n;
      base_addr     = b;
      is_last_layer = last;
      start         = 1'b1;
      tick(1);
      start         = 1'b0;
   endtask

   task automatic send(input logic [7:0] a);
      vld_i = 1'b1;
      act_i = a;
      tick(1);
      vld_i = 1'b0;
   endtask

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
   endtask

   int last_cyc;
   int st_cyc;
   int dc0;
   logic [127:0] exp6;

   initial begin
      rstn = 1'b0; start = 1'b0; num_act = '0; base_addr = '0;
      is_last_layer = 1'b0; vld_i = 1'b0; act_i = '0;
      tick(2);
      chk("rst_w_en",     w_en,     0);
      chk("rst_w_addr",   w_addr,   0);
      chk("rst_w_data",   w_data,   0);
      chk("rst_busy",     busy,     0);
      chk("rst_done",     done,     0);
      chk("rst_drop_err", drop_err, 0);
      rstn = 1'b1;
      tick(2);

      // T1: one full word
      clear_log(); dc0 = done_cnt;
      start_layer(16, 8'h10, 1'b0);
      chk("t1_busy", busy, 1);
      for (int i = 1; i <= 16; i++) begin
         last_cyc = cyc;
         send(8'(i));
      end
      tick(4);
      chk("t1_nwr",  wa_q.size(), 1);
      chk("t1_addr", wa_q[0], 8'h10);
      chk("t1_data", wd_q[0], 128'h100F0E0D0C0B0A090807060504030201);
      chk("t1_done_lat", done_cyc - last_cyc, 2);
      chk("t1_done_cnt", done_cnt - dc0, 1);
      chk("t1_busy_end", busy, 0);
      chk("t1_hold_addr", w_addr, 8'h10);
      chk("t1_hold_data", w_data, 128'h100F0E0D0C0B0A090807060504030201);
      chk("t1_drop", drop_err, 0);

      // T2: one full word plus a partial flush
      clear_log();
      start_layer(20, 8'h00, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         last_cyc = cyc;
         send(8'(i));
      end
      tick(4);
      chk("t2_nwr",   wa_q.size(), 2);
      chk("t2_addr0", wa_q[0], 8'h00);
      chk("t2_data0", wd_q[0], 128'h100F0E0D0C0B0A090807060504030201);
      chk("t2_addr1", wa_q[1], 8'h01);
      chk("t2_data1", wd_q[1], 128'h00000000000000000000000014131211);
      chk("t2_done_lat", done_cyc - last_cyc, 2);

      // T3: vld_i toggling every cycle
      clear_log();
      start_layer(32, 8'h05, 1'b0);
      for (int i = 1; i <= 32; i++) begin
         send(8'(i));
         tick(1);
      end
      tick(3);
      chk("t3_nwr",   wa_q.size(), 2);
      chk("t3_addr0", wa_q[0], 8'h05);
      chk("t3_data0", wd_q[0], 128'h100F0E0D0C0B0A090807060504030201);
      chk("t3_addr1", wa_q[1], 8'h06);
      chk("t3_data1", wd_q[1], 128'h201F1E1D1C1B1A191817161514131211);
      chk("t3_drop",  drop_err, 0);

      // T4: address wrap
      clear_log();
      start_layer(32, 8'hFF, 1'b0);
      for (int i = 1; i <= 32; i++) send(8'(i));
      tick(4);
      chk("t4_nwr",   wa_q.size(), 2);
      chk("t4_addr0", wa_q[0], 8'hFF);
      chk("t4_addr1", wa_q[1], 8'h00);
      chk("t4_data1", wd_q[1], 128'h201F1E1D1C1B1A191817161514131211);

      // Excess activation dropped; start while busy ignored
      clear_log();
      start_layer(2, 8'h40, 1'b0);
      send(8'h01);
      start_layer(5, 8'h80, 1'b0);
      send(8'h02);
      send(8'h03);
      tick(4);
      chk("xs_nwr",  wa_q.size(), 1);
      chk("xs_addr", wa_q[0], 8'h40);
      chk("xs_data", wd_q[0], 128'h0201);
      chk("xs_drop", drop_err, 1);

      // start and vld_i in the same cycle
      clear_log();
      vld_i = 1'b1; act_i = 8'h55;
      start_layer(1, 8'h50, 1'b0);
      vld_i = 1'b0;
      chk("sv_drop_now", drop_err, 1);
      send(8'h66);
      tick(4);
      chk("sv_nwr",  wa_q.size(), 1);
      chk("sv_addr", wa_q[0], 8'h50);
      chk("sv_data", wd_q[0], 128'h66);
      chk("sv_drop", drop_err, 1);

      // T5: empty layer, then a stray activation in IDLE
      clear_log(); dc0 = done_cnt;
      st_cyc = cyc;
      start_layer(0, 8'h33, 1'b0);
      chk("t5_drop_clr", drop_err, 0);
      tick(4);
      chk("t5_nwr", wa_q.size(), 0);
      chk("t5_done_lat", done_cyc - st_cyc, 2);
      chk("t5_done_cnt", done_cnt - dc0, 1);
      send(8'hAA);
      tick(1);
      chk("t5_drop_set", drop_err, 1);
      tick(5);
      chk("t5_drop_sticky", drop_err, 1);

      // T6: sign-dependent storage across layer kinds
      clear_log();
      start_layer(16, 8'h20, 1'b0);
      chk("t6_drop_clr", drop_err, 0);
      for (int r = 0; r < 4; r++) begin
         send(8'h80); send(8'h7F); send(8'hFF); send(8'h00);
      end
      tick(4);
`ifdef CONV_OUT_RELU_EN
      exp6 = {4{32'h00007F00}};
`else
      exp6 = {4{32'h00FF7F80}};
`endif
      chk("t6_nwr",    wa_q.size(), 1);
      chk("t6_data_0", wd_q[0], exp6);
      clear_log();
      start_layer(16, 8'h21, 1'b1);
      for (int r = 0; r < 4; r++) begin
         send(8'h80); send(8'h7F); send(8'hFF); send(8'h00);
      end
      tick(4);
      chk("t6_addr_1", wa_q[0], 8'h21);
      chk("t6_data_1", wd_q[0], {4{32'h00FF7F80}});

      // Reset in the middle of a word
      clear_log(); dc0 = done_cnt;
      start_layer(16, 8'h30, 1'b0);
      for (int i = 1; i <= 5; i++) send(8'(i));
      rstn = 1'b0;
      #3;
      chk("mr_busy",   busy,   0);
      chk("mr_w_en",   w_en,   0);
      chk("mr_w_addr", w_addr, 0);
      chk("mr_w_data", w_data, 0);
      tick(1);
      rstn = 1'b1;
      tick(20);
      chk("mr_nwr",  wa_q.size(), 0);
      chk("mr_done", done_cnt - dc0, 0);
      chk("mr_busy_after", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
